alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised-width successor to the combinational 16-bit ALU. Same opcode/flag model, plus a persistent flags register and a valid/ready input handshake.
- Adds an iterative shift-add multiplier; all other ops complete in one cycle.
- Sits between the register-file read ports and the writeback mux of the datapath.

Parameters:
- WIDTH, 16, operand/result width (>=4).
- OPW, 8, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; signed shift amount for shifts.
- Opcode  in  OPW  operation select.
- C  out  WIDTH  registered result; held until the next result.
- Flags  out  5  persistent flags {N,Z,F,L,C} = bits [4:0] in the order [4]N [3]Z [2]F [1]L [0]C.
- out_valid  out  1  one-cycle pulse when C/Flags update.
- illegal  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset (asynchronous, any state, including mid-MUL): C=0, Flags=0, out_valid=0, illegal=0, state=IDLE; any in-flight op is discarded. in_ready=1 once reset_n is high.
- Accept on the rising edge where in_valid && in_ready. Operands are captured; later changes are ignored.
- States:
  - IDLE: in_ready=1. Single-cycle op → result/flags registered at the accept edge; out_valid=1 the following cycle; stay IDLE. Throughput is 1 op/cycle back-to-back.
  - MUL: in_ready=0. Entered on an accepted MUL; iteration counter counts WIDTH cycles; on the last iteration C and Flags are written and the state returns to IDLE. out_valid rises WIDTH+1 cycles after the accept edge.
- Opcodes (zero-extended to OPW):
  - 0x00 ADD: C=A+B mod 2^WIDTH. Sets C=carry-out, F=signed overflow, Z/N from result.
  - 0x01 SUB: C=A-B. C=borrow (A<B unsigned), F=signed overflow, Z/N from result.
  - 0x02 CMP: C unchanged (result register keeps its previous value). Z=(A==B), L=(A<B unsigned), N=(A<B signed); C/F flags unchanged.
  - 0x03 AND, 0x04 OR, 0x05 XOR: Z/N from result; C, F, L unchanged.
  - 0x06 LSH: B>=0 → A<<B, B<0 → A>>>|B| logical. |B|>=WIDTH → 0. No flags.
  - 0x07 ASH: as LSH, but right shift sign-fills. |B|>=WIDTH right → all sign bits.
  - 0x08 MUL: unsigned; C = low WIDTH bits of A*B. F=1 iff high WIDTH bits are nonzero. Z/N from result.
  - 0x09 MOV: C=B; no flags.
  - Other values: C and Flags unchanged; illegal pulses and out_valid pulses in the cycle after accept.
- Flags not named for an op hold their value. L is written only by CMP.
- in_valid while in_ready=0: not accepted; the upstream must hold its request.

Optional Feature:
- ALU_MUL_EN
  - Defined: MUL state and multiplier as above.
  - Undefined: no MUL state or multiplier hardware; in_ready is tied to 1; opcode 0x08 is treated as illegal.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD..OP_MOV).
  - flag bit indices (FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4).
  - state enum {IDLE, MUL}.
- Sub-module alu_seq_mul: iterative shift-add multiplier.
  - Ports: start/done handshake, WIDTH-bit A/B, 2*WIDTH product.
  - Compiled only under ALU_MUL_EN.

Test Plan:
- ADD sweep, WIDTH=16: i=0..31, A=i, B=3*i, back-to-back with in_valid held high → each C=4*i, one cycle after its accept; in_ready stays 1; Z=1 only for i=0.
- Overflow/carry: ADD A=0x7FFF, B=1 → C=0x8000, F=1, C-flag=0, N=1. ADD A=0xFFFF, B=1 → C=0, C-flag=1, Z=1.
- CMP: A=5, B=0xFFF9 (−7) → L=1, N=0, Z=0. C output and C/F flags are unchanged from the previous op.
- MUL (ALU_MUL_EN defined): A=300, B=300 → out_valid at accept+17, C=0x5F90, F=1. in_ready=0 for 16 cycles; a second request held during that window is accepted when in_ready returns to 1.
- Shifts: LSH A=0x00F0, B=−4 → 0x000F. ASH A=0x8000, B=−20 → 0xFFFF. LSH B=16 → 0.
- Reset and illegal op:
  - Assert reset_n=0 mid-MUL (cycle 5) → C=0, Flags=0 immediately, in_ready=1 after release, no out_valid.
  - Opcode 0xAA → illegal pulse, C and Flags unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_seq.
package alu_seq_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_CMP = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 5;
  localparam int OP_LSH = 6;
  localparam int OP_ASH = 7;
  localparam int OP_MUL = 8;
  localparam int OP_MOV = 9;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Built only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               run_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_d;

  // The final partial sum is exposed combinationally so the owner can
  // register it on the same edge as the last iteration.
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU with persistent {N,Z,F,L,C} flags and a valid/ready input.
// Define ALU_MUL_EN to add the iterative multiplier and the MUL state.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   Opcode,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       Flags,
  output logic             out_valid,
  output logic             illegal,
  output state_e           dbg_state
);

  // Handshake: an op is taken on a rising edge with in_valid && in_ready;
  // while in_ready is low the upstream holds its request unchanged.
  localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

  logic             accept;
  logic [WIDTH-1:0] c_q, c_d;
  logic [4:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;
  logic             set_zn;
  logic [WIDTH-1:0] sum, diff, shamt, lsh_r, ash_r;
  logic             carry, borrow, neg_b;

  assign accept         = in_valid && in_ready;
  assign {carry, sum}   = {1'b0, A} + {1'b0, B};
  assign {borrow, diff} = {1'b0, A} - {1'b0, B};
  assign neg_b          = B[WIDTH-1];
  assign shamt          = neg_b ? (-B) : B;

  always_comb begin
    lsh_r = '0;
    ash_r = {WIDTH{A[WIDTH-1]}};
    if (!neg_b) begin
      ash_r = '0;
      if (shamt < W_AMT) begin
        lsh_r = A << shamt;
        ash_r = A << shamt;
      end
    end else if (shamt < W_AMT) begin
      lsh_r = A >> shamt;
      ash_r = $unsigned($signed(A) >>> shamt);
    end
  end

`ifdef ALU_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  state_e             state_q, state_d;
`endif

  always_comb begin
    c_d         = c_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    set_zn      = 1'b0;
`ifdef ALU_MUL_EN
    mul_start   = 1'b0;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      case (Opcode)
        OPW'(OP_ADD): begin
          c_d             = sum;
          flags_d[FLAG_C] = carry;
          flags_d[FLAG_F] = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          set_zn          = 1'b1;
        end
        OPW'(OP_SUB): begin
          c_d             = diff;
          flags_d[FLAG_C] = borrow;
          flags_d[FLAG_F] = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
          set_zn          = 1'b1;
        end
        OPW'(OP_CMP): begin
          flags_d[FLAG_Z] = (A == B);
          flags_d[FLAG_L] = borrow;
          flags_d[FLAG_N] = ($signed(A) < $signed(B));
        end
        OPW'(OP_AND): begin c_d = A & B; set_zn = 1'b1; end
        OPW'(OP_OR):  begin c_d = A | B; set_zn = 1'b1; end
        OPW'(OP_XOR): begin c_d = A ^ B; set_zn = 1'b1; end
        OPW'(OP_LSH): c_d = lsh_r;
        OPW'(OP_ASH): c_d = ash_r;
        OPW'(OP_MOV): c_d = B;
`ifdef ALU_MUL_EN
        OPW'(OP_MUL): begin
          out_valid_d = 1'b0;
          mul_start   = 1'b1;
        end
`endif
        default: illegal_d = 1'b1;
      endcase
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      out_valid_d     = 1'b1;
      c_d             = mul_prod[WIDTH-1:0];
      flags_d[FLAG_F] = |mul_prod[2*WIDTH-1:WIDTH];
      set_zn          = 1'b1;
    end
`endif
    if (set_zn) begin
      flags_d[FLAG_Z] = (c_d == '0);
      flags_d[FLAG_N] = c_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      c_q         <= c_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign C         = c_q;
  assign Flags     = flags_q;
  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    dbg_state = state_q;
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign in_ready  = 1'b1;
  assign dbg_state = IDLE;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16); follows ALU_MUL_EN when defined.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B, C;
  logic [7:0]  Opcode;
  logic [4:0]  Flags;
  logic        out_valid, illegal;
  state_e      dbg_state;

  alu_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .C         (C),
    .Flags     (Flags),
    .out_valid (out_valid),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {illegal, flags[4:0], C[15:0]} and the cycle out_valid is due
  logic [21:0] exp_q[$];
  int          cyc_q[$];
  logic [15:0] m_c = '0;
  logic [4:0]  m_f = '0;

  task automatic model_push(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] wide;
    logic [31:0] prod;
    logic        ill;
    int          sh;
    int          lat;
    ill = 1'b0;
    lat = 1;
    sh  = int'($signed(b));
    case (op)
      8'h00: begin
        wide = {1'b0, a} + {1'b0, b};
        m_c = wide[15:0];
        m_f[0] = wide[16];
        m_f[2] = (a[15] == b[15]) && (m_c[15] != a[15]);
        m_f[3] = (m_c == 16'h0); m_f[4] = m_c[15];
      end
      8'h01: begin
        m_c = a - b;
        m_f[0] = (a < b);
        m_f[2] = (a[15] != b[15]) && (m_c[15] != a[15]);
        m_f[3] = (m_c == 16'h0); m_f[4] = m_c[15];
      end
      8'h02: begin
        m_f[3] = (a == b);
        m_f[1] = (a < b);
        m_f[4] = ($signed(a) < $signed(b));
      end
      8'h03, 8'h04, 8'h05: begin
        m_c = (op == 8'h03) ? (a & b) : (op == 8'h04) ? (a | b) : (a ^ b);
        m_f[3] = (m_c == 16'h0); m_f[4] = m_c[15];
      end
      8'h06: begin
        if (sh >= 0) m_c = (sh >= 16) ? 16'h0 : (a << sh);
        else         m_c = (-sh >= 16) ? 16'h0 : (a >> (-sh));
      end
      8'h07: begin
        if (sh >= 0) m_c = (sh >= 16) ? 16'h0 : (a << sh);
        else         m_c = (-sh >= 16) ? {16{a[15]}} : 16'($signed(a) >>> (-sh));
      end
`ifdef ALU_MUL_EN
      8'h08: begin
        prod = {16'h0, a} * {16'h0, b};
        m_c = prod[15:0];
        m_f[2] = (prod[31:16] != 16'h0);
        m_f[3] = (m_c == 16'h0); m_f[4] = m_c[15];
        lat = 17;
      end
`endif
      8'h09: m_c = b;
      default: ill = 1'b1;
    endcase
    exp_q.push_back({ill, m_f, m_c});
    cyc_q.push_back(cyc + lat);
  endtask

  // driver: holds the request until in_ready, returns at the negedge after accept
  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      output int waits);
    waits = 0;
    in_valid = 1'b1; Opcode = op; A = a; B = b;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check_val("ready_timeout", in_ready, 1);
    model_push(op, a, b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [21:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_val("unexpected_out", out_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          mon_c = cyc_q.pop_front();
          check_val("res_c", C, mon_e[15:0]);
          check_val("res_flags", Flags, mon_e[20:16]);
          check_val("res_illegal", illegal, mon_e[21]);
          check_val("res_cycle", cyc, mon_c);
        end
      end else if (illegal) check_val("illegal_no_valid", illegal, 0);
    end
  end

  initial begin
    int w, n, acc, tmp;
    logic [7:0]  op;
    logic [15:0] ra, rb;
    reset_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Opcode = '0;
    repeat (3) @(negedge clk);
    check_val("rst_c", C, 0);
    check_val("rst_flags", Flags, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_illegal", illegal, 0);
    check_val("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", in_ready, 1);

    // ADD sweep, back-to-back
    for (int i = 0; i < 32; i++) begin
      check_val("sweep_ready", in_ready, 1);
      send(8'h00, 16'(i), 16'(3 * i), w);
    end
    idle(2);

    send(8'h00, 16'h7FFF, 16'h0001, w);
    check_val("ovf_c", C, 16'h8000);
    check_val("ovf_flags", Flags, 5'b10100);
    send(8'h00, 16'hFFFF, 16'h0001, w);
    check_val("carry_c", C, 16'h0000);
    check_val("carry_flags", Flags, 5'b01001);
    send(8'h02, 16'h0005, 16'hFFF9, w);
    check_val("cmp_c", C, 16'h0000);
    check_val("cmp_flags", Flags, 5'b00011);
    idle(1);

    send(8'h06, 16'h00F0, 16'hFFFC, w);
    check_val("lsh_right", C, 16'h000F);
    send(8'h07, 16'h8000, 16'hFFEC, w);
    check_val("ash_right_big", C, 16'hFFFF);
    send(8'h06, 16'h1234, 16'd16, w);
    check_val("lsh_left_big", C, 16'h0000);
    idle(1);

`ifdef ALU_MUL_EN
    send(8'h08, 16'd300, 16'd300, w);
    acc = cyc - 1;
    in_valid = 1'b0;
    check_val("mul_state", dbg_state, MUL);
    check_val("mul_ready_low", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check_val("mul_latency", cyc - acc, 17);
    check_val("mul_c", C, 16'h5F90);
    check_val("mul_f", Flags[2], 1);
    idle(1);
    send(8'h08, 16'd300, 16'd7, w);
    send(8'h00, 16'd1, 16'd2, w);
    check_val("held_req_waits", w, 16);
    idle(2);
`endif

    // random mix
    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(0, 9));
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (op == 8'h06 || op == 8'h07) begin
        tmp = int'($urandom_range(0, 40)) - 20;
        rb = tmp[15:0];
      end
      send(op, ra, rb, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(20);

    send(8'hAA, 16'h1111, 16'h2222, w);
    check_val("ill_pulse", illegal, 1);
    check_val("ill_c", C, m_c);
    check_val("ill_flags", Flags, m_f);
    idle(1);
    check_val("ill_clear", illegal, 0);

    // reset in the middle of an operation (MUL when built in)
    send(8'h08, 16'd1234, 16'd5678, w);
    idle(4);
    #1 reset_n = 1'b0;
    #1;
    check_val("midrst_c", C, 0);
    check_val("midrst_flags", Flags, 0);
    check_val("midrst_out_valid", out_valid, 0);
    exp_q.delete(); cyc_q.delete();
    m_c = '0; m_f = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", in_ready, 1);
    idle(20);
    send(8'h01, 16'd3, 16'd5, w);
    idle(3);
    check_val("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%0h expected 0x%0h", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
